// File: rtl/spell_mem_router_if.sv
// spell_mem_router_if: CPU-side request/response plus internal-memory and IO target buses
interface spell_mem_router_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              select;
  logic              write;
  logic              memory_type_data;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              data_ready;
  logic              bus_error;
  logic              mem_select;
  logic              mem_write;
  logic              mem_type_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              io_select;
  logic              io_write;
  logic [ADDR_W-1:0] io_addr;
  logic [DATA_W-1:0] io_wdata;
  logic [DATA_W-1:0] io_rdata;
  logic              io_ready;
  modport slave (
    input  select, write, memory_type_data, addr, data_in,
    output data_out, data_ready, bus_error,
    output mem_select, mem_write, mem_type_data, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready,
    output io_select, io_write, io_addr, io_wdata,
    input  io_rdata, io_ready
  );
  modport master (
    output select, write, memory_type_data, addr, data_in,
    input  data_out, data_ready, bus_error,
    input  mem_select, mem_write, mem_type_data, mem_addr, mem_wdata,
    output mem_rdata, mem_ready,
    input  io_select, io_write, io_addr, io_wdata,
    output io_rdata, io_ready
  );
endinterface

// File: rtl/spell_mem_router.sv
// spell_mem_router: routes one CPU access to internal memory or the IO window, with a wait timeout
module spell_mem_router #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int IO_BASE  = 'h20,
  parameter int IO_LIMIT = 'h60,
  parameter int TIMEOUT  = 15
) (
  input logic clk,
  input logic rst,
  spell_mem_router_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(IO_BASE);
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(IO_LIMIT);
  localparam logic [7:0]        TO    = 8'(TIMEOUT);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, dout_q, dout_d;
  logic              write_q, write_d, type_q, type_d;
  logic              rdy_q, rdy_d, err_q, err_d, msel_q, msel_d, isel_q, isel_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              in_io, in_tgt, ready;
  logic [DATA_W-1:0] rdata;
  // an empty window (BASE >= LIMIT) falls out of the two unsigned compares
  assign in_io  = bus.memory_type_data && bus.addr >= BASE && bus.addr < LIMIT;
  assign in_tgt = state_q == MEM || state_q == IO;
  assign ready  = state_q == IO ? bus.io_ready : bus.mem_ready;
  assign rdata  = state_q == IO ? bus.io_rdata : bus.mem_rdata;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    type_d  = type_q;
    dout_d  = dout_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    rdy_d   = 1'b0;
    if (state_q == IDLE && bus.select) begin
      addr_d  = bus.addr;
      wdata_d = bus.data_in;
      write_d = bus.write;
      type_d  = bus.memory_type_data;
      err_d   = 1'b0;
      cnt_d   = 8'd0;
      state_d = in_io ? IO : MEM;
    end else if (in_tgt && ready) begin
      dout_d  = write_q ? dout_q : rdata;
      rdy_d   = 1'b1;
      state_d = DONE;
    end else if (in_tgt) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == TO) begin
        dout_d  = '1;
        err_d   = 1'b1;
        rdy_d   = 1'b1;
        state_d = DONE;
      end
    end else if (state_q == DONE && !bus.select) begin
      state_d = IDLE;
    end
    msel_d = state_d == MEM;
    isel_d = state_d == IO;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      type_q  <= 1'b0;
      dout_q  <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      msel_q  <= 1'b0;
      isel_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      type_q  <= type_d;
      dout_q  <= dout_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      msel_q  <= msel_d;
      isel_q  <= isel_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.data_out      = dout_q;
  assign bus.data_ready    = rdy_q;
  assign bus.bus_error     = err_q;
  assign bus.mem_select    = msel_q;
  assign bus.mem_write     = write_q;
  assign bus.mem_type_data = type_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.io_select     = isel_q;
  assign bus.io_write      = write_q;
  assign bus.io_addr       = addr_q;
  assign bus.io_wdata      = wdata_q;
endmodule

// File: tb/tb_spell_mem_router.sv
// tb_spell_mem_router: directed accesses; expected completions queued and checked by a monitor
module tb_spell_mem_router;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mism = 0;
  logic [7:0] model_dout = 8'h00;
  typedef struct {
    logic [7:0] d;
    logic       e;
    int         lat;
    int         issue;
  } exp_t;
  exp_t sbq[$];
  spell_mem_router_if #(.ADDR_W(8), .DATA_W(8)) bus();
  spell_mem_router dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mism++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && bus.data_ready) begin
      if (sbq.size() == 0) chk("unexpected_data_ready", 1, 0);
      else begin
        exp_t x;
        x = sbq.pop_front();
        chk("data_out", bus.data_out, x.d);
        chk("bus_error", bus.bus_error, x.e);
        chk("latency", cyc - x.issue, x.lat);
      end
    end
  end
  task automatic access(input logic t, input logic w, input logic [7:0] a, input logic [7:0] d,
                        input logic exp_io, input int delay, input logic [7:0] rdata, input int hold);
    exp_t x;
    logic [7:0] ed;
    int n;
    @(posedge clk); #1;
    ed = delay < 0 ? 8'hFF : (w ? model_dout : rdata);
    model_dout = ed;
    x = '{ed, delay < 0, delay < 0 ? 16 : 2 + delay, cyc};
    sbq.push_back(x);
    bus.select = 1'b1;
    bus.write = w;
    bus.memory_type_data = t;
    bus.addr = a;
    bus.data_in = d;
    bus.io_rdata  = exp_io ? rdata : ~rdata;
    bus.mem_rdata = exp_io ? ~rdata : rdata;
    bus.io_ready  = !exp_io;
    bus.mem_ready = exp_io;
    @(posedge clk); #1;
    chk("io_select", bus.io_select, exp_io);
    chk("mem_select", bus.mem_select, !exp_io);
    chk("tgt_addr", exp_io ? bus.io_addr : bus.mem_addr, a);
    chk("tgt_write", exp_io ? bus.io_write : bus.mem_write, w);
    if (w) chk("tgt_wdata", exp_io ? bus.io_wdata : bus.mem_wdata, d);
    if (!exp_io) chk("mem_type_data", bus.mem_type_data, t);
    chk("err_cleared", bus.bus_error, 0);
    bus.addr = ~a;
    bus.data_in = ~d;
    bus.write = ~w;
    bus.memory_type_data = ~t;
    for (int i = 0; i < delay; i++) begin @(posedge clk); #1; end
    if (delay >= 0) begin
      if (exp_io) bus.io_ready = 1'b1;
      else bus.mem_ready = 1'b1;
    end
    n = 0;
    while (!bus.data_ready && n < 40) begin @(posedge clk); #1; n++; end
    chk("completion_seen", n < 40, 1);
    chk("addr_stable", exp_io ? bus.io_addr : bus.mem_addr, a);
    bus.io_ready = 1'b0;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin @(posedge clk); #1; end
    if (hold > 0) begin
      chk("done_selects_low", {bus.io_select, bus.mem_select}, 0);
      chk("done_no_repulse", bus.data_ready, 0);
    end
    bus.select = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.select = 0; bus.write = 0; bus.memory_type_data = 0; bus.addr = 0; bus.data_in = 0;
    bus.mem_rdata = 0; bus.mem_ready = 1; bus.io_rdata = 0; bus.io_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_flags", {bus.data_ready, bus.bus_error, bus.mem_select, bus.io_select}, 0);
    chk("rst_req_regs", {bus.mem_addr, bus.mem_wdata, bus.mem_write, bus.mem_type_data}, 0);
    rst = 1'b0;
    bus.mem_ready = 0; bus.io_ready = 0;
    //      t  w  addr   data   io delay rdata  hold
    access(1, 0, 8'h25, 8'h00, 1,  0, 8'h5A, 0);
    access(0, 0, 8'h25, 8'h00, 0,  0, 8'h3C, 0);
    access(1, 1, 8'h60, 8'hC3, 0,  0, 8'hEE, 0);
    access(1, 0, 8'h1F, 8'h00, 0,  2, 8'h11, 0);
    access(1, 0, 8'h5F, 8'h00, 1,  1, 8'h77, 0);
    access(1, 1, 8'h20, 8'h99, 1,  0, 8'h12, 0);
    access(1, 0, 8'h30, 8'h00, 1, -1, 8'h55, 0);
    access(0, 0, 8'h80, 8'h00, 0, 14, 8'h42, 0);
    access(0, 0, 8'h05, 8'h00, 0, -1, 8'h66, 0);
    access(1, 0, 8'h40, 8'h00, 1,  0, 8'hA5, 10);
    @(posedge clk); #1;
    bus.select = 1; bus.write = 0; bus.memory_type_data = 0; bus.addr = 8'h10; bus.data_in = 8'h00;
    @(posedge clk); #1;
    chk("pre_rst_mem_select", bus.mem_select, 1);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_mem_select", bus.mem_select, 0);
    chk("midrst_data_ready", bus.data_ready, 0);
    chk("midrst_outputs", {bus.data_out, bus.bus_error, bus.io_select, bus.mem_addr}, 0);
    rst = 1'b0;
    bus.select = 0;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_data_ready", bus.data_ready, 0);
    chk("queue_empty", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
